// File: rtl/dm_dmi_arbiter.sv
// Shares the debug module's single DMI port between the JTAG DTM (port 0) and the SoC mailbox (port 1).
// Optional DM response timeout: define DM_DMI_ARB_TIMEOUT_EN.
module dm_dmi_arbiter #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [65:0] req0_i,
    output logic        resp0_valid_o,
    input  logic        resp0_ready_i,
    output logic [33:0] resp0_o,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [65:0] req1_i,
    output logic        resp1_valid_o,
    input  logic        resp1_ready_i,
    output logic [33:0] resp1_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [65:0] dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i,
    output logic        grant_o
);

    typedef enum logic [1:0] {IDLE, FWD, WAIT, RET} state_e;

    localparam logic [33:0] TimeoutResp = {32'h0, 2'h2};

    if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("dm_dmi_arbiter: TimeoutCycles out of range 2..65535");
    end

    state_e      state_q;
    logic        ptr_q;
    logic        grant_q;
    logic [65:0] req_q;
    logic [33:0] resp0_q;
    logic [33:0] resp1_q;
    logic        any_valid;
    logic        sel;
    logic        tmo_hit;
    logic [33:0] resp_d;

    // Pointer only matters when both ports compete.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        sel       = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            sel = ptr_q;
        end else begin
            sel = req1_valid_i;
        end
        resp_d = dmi_resp_valid_i ? dmi_resp_i : TimeoutResp;
    end

`ifdef DM_DMI_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == 16'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == FWD) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            req_q   <= '0;
            resp0_q <= '0;
            resp1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        req_q   <= sel ? req1_i : req0_i;
                        grant_q <= sel;
                        ptr_q   <= ~sel;
                        state_q <= FWD;
                    end
                end
                FWD: begin
                    if (dmi_req_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A real response wins over a timeout in the same cycle.
                    if (dmi_resp_valid_i || tmo_hit) begin
                        if (grant_q) begin
                            resp1_q <= resp_d;
                        end else begin
                            resp0_q <= resp_d;
                        end
                        state_q <= RET;
                    end
                end
                RET: begin
                    if (grant_q ? resp1_ready_i : resp0_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stray responses in IDLE are accepted and dropped.
    assign req0_ready_o     = (state_q == IDLE) && any_valid && !sel;
    assign req1_ready_o     = (state_q == IDLE) && any_valid && sel;
    assign dmi_req_valid_o  = (state_q == FWD);
    assign dmi_req_o        = req_q;
    assign dmi_resp_ready_o = (state_q == IDLE) || (state_q == WAIT);
    assign resp0_valid_o    = (state_q == RET) && !grant_q;
    assign resp1_valid_o    = (state_q == RET) && grant_q;
    assign resp0_o          = resp0_q;
    assign resp1_o          = resp1_q;
    assign grant_o          = grant_q;

endmodule

// File: tb/tb_dm_dmi_arbiter.sv
// Directed bench for dm_dmi_arbiter: reset values, single transfer, contention, backpressure, passthrough, reset, timeout.
module tb_dm_dmi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_valid_i, req0_ready_o, resp0_valid_o, resp0_ready_i;
    logic [65:0] req0_i;
    logic [33:0] resp0_o;
    logic        req1_valid_i, req1_ready_o, resp1_valid_o, resp1_ready_i;
    logic [65:0] req1_i;
    logic [33:0] resp1_o;
    logic        dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
    logic [65:0] dmi_req_o;
    logic [33:0] dmi_resp_i;
    logic        grant_o;

    int n_pass = 0;
    int n_total = 0;

    dm_dmi_arbiter #(.TimeoutCycles(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_i(req0_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_o(resp0_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_i(req1_i),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_o(resp1_o),
        .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i), .dmi_req_o(dmi_req_o),
        .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_i(dmi_resp_i),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req0_ready"}, 66'(req0_ready_o), 66'd0);
        chk({tag, "_req1_ready"}, 66'(req1_ready_o), 66'd0);
        chk({tag, "_dmi_req_valid"}, 66'(dmi_req_valid_o), 66'd0);
        chk({tag, "_dmi_req"}, dmi_req_o, 66'd0);
        chk({tag, "_dmi_resp_ready"}, 66'(dmi_resp_ready_o), 66'd1);
        chk({tag, "_resp0_valid"}, 66'(resp0_valid_o), 66'd0);
        chk({tag, "_resp1_valid"}, 66'(resp1_valid_o), 66'd0);
        chk({tag, "_resp0"}, 66'(resp0_o), 66'd0);
        chk({tag, "_resp1"}, 66'(resp1_o), 66'd0);
        chk({tag, "_grant"}, 66'(grant_o), 66'd0);
    endtask

    // Zero-wait transaction starting in IDLE with requests already driven.
    task automatic txn(input string tag, input logic port, input logic [65:0] exp_req,
                       input logic [33:0] resp, input bit drop);
        #1;
        chk({tag, "_ready_win"}, 66'(port ? req1_ready_o : req0_ready_o), 66'd1);
        chk({tag, "_ready_lose"}, 66'(port ? req0_ready_o : req1_ready_o), 66'd0);
        tick();
        if (drop) begin
            if (port) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
        end
        chk({tag, "_grant"}, 66'(grant_o), 66'(port));
        chk({tag, "_dmi_valid"}, 66'(dmi_req_valid_o), 66'd1);
        chk({tag, "_dmi_req"}, dmi_req_o, exp_req);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = resp;
        #1;
        chk({tag, "_dmi_resp_ready"}, 66'(dmi_resp_ready_o), 66'd1);
        tick();
        dmi_resp_valid_i = 1'b0;
        chk({tag, "_resp_valid"}, 66'(port ? resp1_valid_o : resp0_valid_o), 66'd1);
        chk({tag, "_other_valid"}, 66'(port ? resp0_valid_o : resp1_valid_o), 66'd0);
        chk({tag, "_resp"}, 66'(port ? resp1_o : resp0_o), 66'(resp));
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        tick();
        resp0_ready_i = 1'b0;
        resp1_ready_i = 1'b0;
        chk({tag, "_resp_done"}, 66'(port ? resp1_valid_o : resp0_valid_o), 66'd0);
    endtask

    logic [65:0] p0, p1, pw;

    initial begin
        rst_ni = 1'b0;
        req0_valid_i = 0; req1_valid_i = 0; req0_i = '0; req1_i = '0;
        resp0_ready_i = 0; resp1_ready_i = 0;
        dmi_req_ready_i = 0; dmi_resp_valid_i = 0; dmi_resp_i = '0;
        tick(); tick();
        check_reset_vals("rst");
        rst_ni = 1'b1;
        tick();

        // Single port-0 read of address 0x11.
        req0_i = {32'h11, 2'h1, 32'h0};
        req0_valid_i = 1'b1;
        txn("rd0", 1'b0, {32'h11, 2'h1, 32'h0}, {32'h00000C82, 2'h0}, 1'b1);

        // Contention from reset: grants alternate 0,1,0,1.
        rst_ni = 1'b0; #2; rst_ni = 1'b1;
        p0 = {32'h100, 2'h1, 32'h0};
        p1 = {32'h200, 2'h2, 32'h55AA55AA};
        req0_i = p0; req1_i = p1;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        txn("ct0", 1'b0, p0, {32'h10, 2'h0}, 1'b0);
        txn("ct1", 1'b1, p1, {32'h11, 2'h0}, 1'b0);
        txn("ct2", 1'b0, p0, {32'h12, 2'h2}, 1'b0);
        txn("ct3", 1'b1, p1, {32'h13, 2'h0}, 1'b0);

        // Backpressure on both DM request and requester response; port 1 keeps waiting.
        pw = {32'h20, 2'h2, 32'h12345678};
        req0_i = pw;
        req1_i = {32'h30, 2'h1, 32'h0};
        #1;
        chk("bp_ready0", 66'(req0_ready_o), 66'd1);
        tick();
        req0_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_dmi_valid", 66'(dmi_req_valid_o), 66'd1);
            chk("bp_dmi_req", dmi_req_o, pw);
            chk("bp_req1_ready", 66'(req1_ready_o), 66'd0);
            tick();
        end
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = {32'hA5A5A5A5, 2'h0};
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_resp0_valid", 66'(resp0_valid_o), 66'd1);
            chk("bp_resp0", 66'(resp0_o), 66'({32'hA5A5A5A5, 2'h0}));
            chk("bp_req1_ready_ret", 66'(req1_ready_o), 66'd0);
            chk("bp_resp1_valid", 66'(resp1_valid_o), 66'd0);
            tick();
        end
        // Port 1 then completes with a BUSY code passed through unchanged.
        resp0_ready_i = 1'b1;
        tick();
        resp0_ready_i = 1'b0;
        txn("busy1", 1'b1, {32'h30, 2'h1, 32'h0}, {32'hDEADBEEF, 2'h3}, 1'b1);

        // Reset while waiting for the DM, then a stray response arrives.
        req0_i = {32'h40, 2'h1, 32'h0};
        req0_valid_i = 1'b1;
        tick();
        req0_valid_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        check_reset_vals("rstw");
        rst_ni = 1'b1;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = {32'h77, 2'h0};
        #1;
        chk("stray_ready", 66'(dmi_resp_ready_o), 66'd1);
        tick();
        dmi_resp_valid_i = 1'b0;
        chk("stray_resp0_valid", 66'(resp0_valid_o), 66'd0);
        chk("stray_resp1_valid", 66'(resp1_valid_o), 66'd0);
        tick();
        chk("stray_resp0_valid2", 66'(resp0_valid_o), 66'd0);
        // Pointer back at port 0 after reset.
        req0_i = {32'h50, 2'h1, 32'h0};
        req1_i = {32'h60, 2'h1, 32'h0};
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        txn("post_rst", 1'b0, {32'h50, 2'h1, 32'h0}, {32'h99, 2'h0}, 1'b1);
        req1_valid_i = 1'b0;

`ifdef DM_DMI_ARB_TIMEOUT_EN
        tick(); tick();
        req0_i = {32'h70, 2'h1, 32'h0};
        req0_valid_i = 1'b1;
        tick();
        req0_valid_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("tmo_wait", 66'(resp0_valid_o), 66'd0);
        end
        tick();
        chk("tmo_valid", 66'(resp0_valid_o), 66'd1);
        chk("tmo_resp", 66'(resp0_o), 66'({32'h0, 2'h2}));
        resp0_ready_i = 1'b1;
        tick();
        resp0_ready_i = 1'b0;
        tick();
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = {32'hBAD, 2'h0};
        tick();
        dmi_resp_valid_i = 1'b0;
        chk("tmo_late_valid", 66'(resp0_valid_o), 66'd0);
        chk("tmo_late_resp", 66'(resp0_o), 66'({32'h0, 2'h2}));
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
